// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Purpose  : Shared types and constants for the iterative CORDIC engine.
//            Controls the optional gain-compensation stage through the macro
//            CORDIC_GAIN_COMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_pkg;

   // Default datapath sizing
   localparam int DEF_WIDTH = 16;
   localparam int DEF_ITER  = 16;
   localparam int DEF_GUARD = 2;

   // +90 degrees in a 16-bit binary angle, full scale = 2*pi
   localparam logic [15:0] ANGLE_QUARTER = 16'h4000;

   // 1/1.64676 in Q1.15, the inverse of the accumulated CORDIC gain
   localparam logic [15:0] CORDIC_K = 16'h4DBA;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      GAIN   = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage : cordic_pkg
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`default_nettype none
// ============================================================================
// Module   : cordic_atan_rom
// Purpose  : Arctangent table, entry i = round(atan(2^-i) * 2^16 / 2pi),
//            rescaled to WIDTH bits (values are truncated when WIDTH < 16).
// Revision : 1.0 - initial release
// ============================================================================
module cordic_atan_rom #(
   parameter int WIDTH = 16
) (
   input  logic [3:0]       i_addr,
   output logic [WIDTH-1:0] o_data
);

   logic [15:0] w_entry;

   // Table lookup at the native 16-bit angle scale
   always_comb begin
      w_entry = 16'h0000;
      case (i_addr)
         4'd0:    w_entry = 16'h2000;
         4'd1:    w_entry = 16'h12E4;
         4'd2:    w_entry = 16'h09FB;
         4'd3:    w_entry = 16'h0511;
         4'd4:    w_entry = 16'h028B;
         4'd5:    w_entry = 16'h0146;
         4'd6:    w_entry = 16'h00A3;
         4'd7:    w_entry = 16'h0051;
         4'd8:    w_entry = 16'h0029;
         4'd9:    w_entry = 16'h0014;
         4'd10:   w_entry = 16'h000A;
         4'd11:   w_entry = 16'h0005;
         4'd12:   w_entry = 16'h0003;
         4'd13:   w_entry = 16'h0001;
         4'd14:   w_entry = 16'h0001;
         default: w_entry = 16'h0000;
      endcase
   end

   if (WIDTH >= 16) begin : g_wide
      assign o_data = WIDTH'(w_entry) << (WIDTH - 16);
   end else begin : g_narrow
      assign o_data = w_entry[15 -: WIDTH];
   end

endmodule : cordic_atan_rom
`default_nettype wire

// File: rtl/cordic_iter_engine.sv
`default_nettype none
// ============================================================================
// Module   : cordic_iter_engine
// Purpose  : Iterative rotation-mode CORDIC, one micro-rotation per clock,
//            valid/ready on both sides, saturated x/y outputs.
//            Define CORDIC_GAIN_COMP_EN to add a gain-compensation state
//            (multiply by 0.60725) before saturation.
//            GUARD must be at least 1.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_iter_engine
   import cordic_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ITER  = DEF_ITER,
   parameter int GUARD = DEF_GUARD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic [WIDTH-1:0] z_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic [WIDTH-1:0] z_out
);

   localparam int c_IW = WIDTH + GUARD;
   localparam logic signed [WIDTH-1:0] c_QUARTER = WIDTH'(1 << (WIDTH - 2));
   localparam logic [3:0] c_LAST = 4'(ITER - 1);
   localparam logic signed [c_IW-1:0] c_SMAX = c_IW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
   localparam logic signed [c_IW-1:0] c_SMIN = c_IW'(-(64'sd1 <<< (WIDTH - 1)));

   state_t                  r_state;
   logic [3:0]              r_cnt;
   logic signed [c_IW-1:0]  r_x, r_y;
   logic signed [WIDTH-1:0] r_z;
   logic                    r_in_ready, r_out_valid;
   logic [WIDTH-1:0]        r_x_out, r_y_out, r_z_out;

   // Clamp the wide internal value into the WIDTH-bit signed output range
   function automatic logic [WIDTH-1:0] f_sat(input logic signed [c_IW-1:0] v);
      logic [WIDTH-1:0] r;
      if (v > c_SMAX)      r = {1'b0, {(WIDTH-1){1'b1}}};
      else if (v < c_SMIN) r = {1'b1, {(WIDTH-1){1'b0}}};
      else                 r = WIDTH'(v);
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Operand load with quadrant pre-rotation into [-90, +90] degrees
   // ------------------------------------------------------------------------
   logic signed [WIDTH-1:0] w_xs, w_ys, w_zs, w_z_load;
   logic signed [c_IW-1:0]  w_xe, w_ye, w_x_load, w_y_load;

   assign w_xs = x_in;
   assign w_ys = y_in;
   assign w_zs = z_in;
   assign w_xe = {{GUARD{w_xs[WIDTH-1]}}, w_xs};
   assign w_ye = {{GUARD{w_ys[WIDTH-1]}}, w_ys};

   // Fold angles beyond +/-90 degrees by a fixed quarter turn
   always_comb begin
      w_x_load = w_xe;
      w_y_load = w_ye;
      w_z_load = w_zs;
      if (w_zs > c_QUARTER) begin
         w_x_load = -w_ye;
         w_y_load = w_xe;
         w_z_load = w_zs - c_QUARTER;
      end else if (w_zs < -c_QUARTER) begin
         w_x_load = w_ye;
         w_y_load = -w_xe;
         w_z_load = w_zs + c_QUARTER;
      end
   end

   // ------------------------------------------------------------------------
   // Micro-rotation datapath
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0]        w_atan;
   logic                    w_dpos;
   logic signed [c_IW-1:0]  w_xsh, w_ysh, w_x_next, w_y_next;
   logic signed [WIDTH-1:0] w_z_next;

   cordic_atan_rom #(.WIDTH(WIDTH)) u_atan_rom (
      .i_addr (r_cnt),
      .o_data (w_atan)
   );

   assign w_dpos   = ~r_z[WIDTH-1];
   assign w_xsh    = r_x >>> r_cnt;
   assign w_ysh    = r_y >>> r_cnt;
   assign w_x_next = w_dpos ? (r_x - w_ysh) : (r_x + w_ysh);
   assign w_y_next = w_dpos ? (r_y + w_xsh) : (r_y - w_xsh);
   assign w_z_next = w_dpos ? (r_z - $signed(w_atan)) : (r_z + $signed(w_atan));

`ifdef CORDIC_GAIN_COMP_EN
   // ------------------------------------------------------------------------
   // Gain compensation: round(v * K / 2^15)
   // ------------------------------------------------------------------------
   localparam int c_PW = c_IW + 17;
   localparam logic signed [c_PW-1:0] c_KX  = c_PW'({1'b0, CORDIC_K});
   localparam logic signed [c_PW-1:0] c_RND = c_PW'(1 << 14);

   logic signed [c_PW-1:0] w_xw, w_yw, w_xp, w_yp;
   logic signed [c_IW-1:0] w_xg, w_yg;

   assign w_xw = c_PW'(r_x);
   assign w_yw = c_PW'(r_y);
   assign w_xp = w_xw * c_KX + c_RND;
   assign w_yp = w_yw * c_KX + c_RND;
   assign w_xg = c_IW'(w_xp >>> 15);
   assign w_yg = c_IW'(w_yp >>> 15);
`endif

   // Control FSM with registered handshake flags and result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= 4'd0;
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_x_out     <= '0;
         r_y_out     <= '0;
         r_z_out     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_x        <= w_x_load;
                  r_y        <= w_y_load;
                  r_z        <= w_z_load;
                  r_cnt      <= 4'd0;
                  r_in_ready <= 1'b0;
                  r_state    <= ROTATE;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            ROTATE: begin
               r_x <= w_x_next;
               r_y <= w_y_next;
               r_z <= w_z_next;
               if (r_cnt == c_LAST) begin
                  r_cnt <= 4'd0;
`ifdef CORDIC_GAIN_COMP_EN
                  r_state <= GAIN;
`else
                  r_x_out     <= f_sat(w_x_next);
                  r_y_out     <= f_sat(w_y_next);
                  r_z_out     <= w_z_next;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
`endif
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            GAIN: begin
`ifdef CORDIC_GAIN_COMP_EN
               r_x_out     <= f_sat(w_xg);
               r_y_out     <= f_sat(w_yg);
               r_z_out     <= r_z;
               r_out_valid <= 1'b1;
               r_state     <= DONE;
`else
               r_state <= IDLE;
`endif
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign x_out     = r_x_out;
   assign y_out     = r_y_out;
   assign z_out     = r_z_out;

endmodule : cordic_iter_engine
`default_nettype wire

// File: tb/tb_cordic_iter_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_iter_engine
// Purpose  : Scoreboard bench for cordic_iter_engine. Expected results are
//            hand-computed; both CORDIC_GAIN_COMP_EN builds are covered.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_iter_engine;

   localparam int IT = 16;
`ifdef CORDIC_GAIN_COMP_EN
   // edges from the handshake edge to the edge raising out_valid
   localparam int LAT = IT + 1;
   localparam logic [15:0] E_X1   = 16'h2000;  // 8192 at unity gain
   localparam logic [15:0] E_NEG1 = 16'hE000;  // -8192
   localparam logic [15:0] E_R3X  = 16'hE95F;  // -5793 (8192*cos 135)
   localparam logic [15:0] E_R3Y  = 16'h16A1;  //  5793
   localparam logic [15:0] E_R4   = 16'h2D41;  // 11585 (16384*cos 45)
   localparam int          T_SAT  = 4;
`else
   localparam int LAT = IT;
   localparam logic [15:0] E_X1   = 16'h34B2;  // 8192*1.64676
   localparam logic [15:0] E_NEG1 = 16'hCB4E;  // -13490
   localparam logic [15:0] E_R3X  = 16'hDABD;  // -9539
   localparam logic [15:0] E_R3Y  = 16'h2543;  //  9539
   localparam logic [15:0] E_R4   = 16'h4A86;  // 11585*1.64676
   localparam int          T_SAT  = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic        in_ready, out_valid;
   logic [15:0] x_in = '0, y_in = '0, z_in = '0;
   logic [15:0] x_out, y_out, z_out;

   cordic_iter_engine #(.WIDTH(16), .ITER(IT), .GUARD(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y_in      (y_in),
      .z_in      (z_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out),
      .y_out     (y_out),
      .z_out     (z_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
      int          txy;
      int          tz;
      int          hs;
      int          id;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_near(input string nm, input logic [15:0] act,
                           input logic [15:0] req, input int tol);
      int d;
      d = int'($signed(act)) - int'($signed(req));
      checks++;
      if (d > tol || d < -tol) begin
         errors++;
         $display("FAIL %s: actual=0x%04h required=0x%04h +/-%0d", nm, act, req, tol);
      end
   endtask

   task automatic chk_eq(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // Monitor: pop and compare on every new result presented by the DUT
   exp_t e;
   logic prev_v = 1'b0;
   always @(negedge clk) begin
      if (reset && out_valid && !prev_v) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: actual=valid required=none");
         end else begin
            e = sb.pop_front();
            chk_near($sformatf("vec%0d_x", e.id), x_out, e.x, e.txy);
            chk_near($sformatf("vec%0d_y", e.id), y_out, e.y, e.txy);
            chk_near($sformatf("vec%0d_z", e.id), z_out, e.z, e.tz);
            chk_eq($sformatf("vec%0d_latency", e.id), cyc - e.hs, LAT);
         end
      end
      prev_v = out_valid;
   end

   // Present one operand set; called just after a falling edge
   task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                       input logic [15:0] ex, input logic [15:0] ey, input int txy,
                       input int id);
      int n;
      in_valid = 1'b1;
      x_in = x; y_in = y; z_in = z;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk_eq($sformatf("vec%0d_accept_timeout", id), 0, 1);
         in_valid = 1'b0;
      end else begin
         sb.push_back('{x:ex, y:ey, z:16'h0000, txy:txy, tz:2, hs:cyc + 1, id:id});
         @(negedge clk);
         in_valid = 1'b0;
         // scrambled operands must not disturb the running rotation
         x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
         chk_eq($sformatf("vec%0d_ready_drop", id), int'(in_ready), 0);
      end
   endtask

   task automatic wait_valid(input int id);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk_eq($sformatf("vec%0d_result_timeout", id), 0, 1);
   endtask

   task automatic run(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                      input logic [15:0] ex, input logic [15:0] ey, input int txy,
                      input int id);
      send(x, y, z, ex, ey, txy, id);
      wait_valid(id);
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] hx, hy;
      // Reset held with in_valid asserted
      in_valid = 1'b1;
      x_in = 16'h1234; y_in = 16'h5678; z_in = 16'h1111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_eq("rst_in_ready", int'(in_ready), 0);
         chk_eq("rst_out_valid", int'(out_valid), 0);
      end
      chk_near("rst_x_out", x_out, 16'h0000, 0);
      chk_near("rst_y_out", y_out, 16'h0000, 0);
      chk_near("rst_z_out", z_out, 16'h0000, 0);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk_eq("ready_after_release", int'(in_ready), 1);

      // Basic rotation and quadrant cases
      run(16'h2000, 16'h0000, 16'h0000, E_X1,   16'h0000, 4, 1);
      run(16'h2000, 16'h0000, 16'h6000, E_R3X,  E_R3Y,    4, 2);
      run(16'h4000, 16'h0000, 16'h2000, E_R4,   E_R4,     4, 3);
      run(16'h2000, 16'h0000, 16'h8000, E_NEG1, 16'h0000, 4, 4);
      run(16'h2000, 16'h0000, 16'h4000, 16'h0000, E_X1,   4, 5);
      run(16'h2000, 16'h0000, 16'hC000, 16'h0000, E_NEG1, 4, 6);

      // Saturation with backpressure
      out_ready = 1'b0;
      send(16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF, T_SAT, 7);
      wait_valid(7);
      hx = x_out; hy = y_out;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk_eq("bp_out_valid", int'(out_valid), 1);
         chk_eq("bp_in_ready", int'(in_ready), 0);
         chk_near("bp_x_hold", x_out, hx, 0);
         chk_near("bp_y_hold", y_out, hy, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk_eq("bp_release_valid", int'(out_valid), 0);
      chk_eq("bp_release_ready", int'(in_ready), 1);

      // Reset at iteration 7 aborts the operation
      send(16'h2000, 16'h0000, 16'h6000, E_R3X, E_R3Y, 4, 8);
      repeat (7) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_eq("abort_out_valid", int'(out_valid), 0);
      chk_eq("abort_in_ready", int'(in_ready), 0);
      chk_near("abort_x_out", x_out, 16'h0000, 0);
      chk_near("abort_y_out", y_out, 16'h0000, 0);
      chk_near("abort_z_out", z_out, 16'h0000, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run(16'h2000, 16'h0000, 16'h0000, E_X1, 16'h0000, 4, 9);

      repeat (3) @(negedge clk);
      chk_eq("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_cordic_iter_engine
`default_nettype wire
